pwm_multi_dt: RTL
=================

# pwm_multi_dt

Parametrised multi-channel PWM generator, the successor to the team's single-channel 11-bit PWM. All channels share one free-running period counter. Each channel compares its duty against that counter and drives a complementary high-side/low-side output pair. Duty updates are double-buffered so they take effect only at a period boundary, and a programmable dead-time gap is inserted between the two outputs. The block sits between the control loop, which supplies duty words, and the gate-driver pins.

## Interface
Parameters:
- WIDTH, 11, counter and duty width; period is 2^WIDTH clocks
- NCH, 2, number of channels
- DT_WIDTH, 6, dead-time count width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- duty  in  NCH*WIDTH  packed duty words; channel i occupies [i*WIDTH +: WIDTH]
- duty_vld  in  1  one-cycle strobe; captures all of `duty` into the pending registers
- deadtime  in  DT_WIDTH  dead-time in clocks, shared by all channels, sampled continuously
- period_start  out  1  registered pulse, high for the first cycle of every period (cnt==0)
- pwm_hi  out  NCH  high-side outputs, registered
- pwm_lo  out  NCH  low-side outputs, registered

## Operation
- cnt: WIDTH-bit up-counter; wraps from 2^WIDTH-1 to 0 with no pause.
- Pending duty:
  - duty_vld=1 loads pending[i] from duty.
  - Multiple strobes within one period: the last one wins.
- Active duty:
  - On the cycle cnt==2^WIDTH-1, active[i] <= pending[i].
  - The new duty therefore governs the whole of the next period.
  - duty_vld on that same cycle: the newly presented value is forwarded directly into active.
- Raw compare: raw_q[i] <= (cnt < active[i]), registered.
  - duty 0 gives raw permanently 0.
  - duty 2^WIDTH-1 gives raw high for all but one cycle per period; 100% duty is not reachable (by design).
- Per-channel dead-time FSM, states:
  - LO: hi=0, lo=1.
  - HI: hi=1, lo=0.
  - DEAD_TO_HI: both outputs 0.
  - DEAD_TO_LO: both outputs 0.
- FSM transitions:
  - LO with raw_q=1 goes to DEAD_TO_HI; dt_cnt loads 0.
  - HI with raw_q=0 goes to DEAD_TO_LO; dt_cnt loads 0.
  - In DEAD_TO_x, dt_cnt increments each cycle. When dt_cnt+1 >= deadtime, the FSM moves to x.
  - If raw_q reverses while in DEAD_TO_x, the FSM moves to the opposite DEAD state with dt_cnt reloaded to 0. Both outputs stay 0 throughout, so a pulse narrower than the dead-time is swallowed.
  - deadtime=0: DEAD states are bypassed and LO and HI swap directly.
- hi and lo are never simultaneously 1, under any input sequence.
- Reset values:
  - cnt=0; pending=0; active=0; raw_q=0.
  - FSM = DEAD_TO_LO with dt_cnt=0.
  - pwm_hi=0, pwm_lo=0, period_start=0.
  - pwm_lo asserts after the first dead-time expires.
- rst_n asserted mid-operation forces both outputs low immediately (asynchronous).

## Timing
- Period is 2^WIDTH cycles; period_start=1 in the cycle where cnt==0.
- cnt becomes equal to active[i] at edge t0. Then:
  - raw_q[i] falls at t0+1.
  - pwm_hi falls at t0+2.
  - pwm_lo rises at t0+2+deadtime.
- Rising edge is symmetric: pwm_lo falls at t+2 and pwm_hi rises at t+2+deadtime.
- deadtime=0: both outputs switch at t+2.
- Duty latency: a strobe in period N takes effect in period N+1. The exception is a strobe on the last cycle of period N, which is also forwarded into period N+1 (see Operation).

## Configuration
- PWM_DEADTIME_EN defined: dead-time FSM as described above.
- PWM_DEADTIME_EN undefined:
  - `deadtime` input is ignored and no FSM is built.
  - pwm_hi <= raw_q and pwm_lo <= ~raw_q, both registered.
  - Outputs reset to hi=0, lo=0, then follow from the first cycle after reset.
  - Edge latency is t0+2 for both outputs.

## Structure
- Package pwm_pkg holds:
  - Default constants PWM_WIDTH=11, PWM_NCH=2, PWM_DT_WIDTH=6.
  - typedef enum dt_state_t {LO, HI, DEAD_TO_HI, DEAD_TO_LO}.
- Sub-module pwm_dt_chan: one channel's raw_q-to-hi/lo FSM with its dt_cnt; instantiated NCH times in a generate loop.
- Top level holds the shared counter, pending/active registers, compare logic and period_start.

## Test plan
- Reset release, WIDTH=4, NCH=1, duty=6, deadtime=2 -> both outputs 0 during reset; lo=1 after the dead-time; then hi is high for 6 of every 16 cycles, with 2-cycle gaps at both edges.
- duty_vld with 10 mid-period, then 3 in the same period -> current period unchanged; the next period uses 3.
- duty=0 and duty=15 (WIDTH=4) -> hi never rises; hi is low exactly one cycle per period, with dead-time around that low.
- deadtime=5, duty=2 -> raw pulse shorter than the dead-time; hi never asserts; lo drops for the pulse plus dead-time; no overlap at any point.
- NCH=3 with duties 4/8/12, deadtime=0 -> each hi/lo pair is complementary; the three channels share period_start; hi rises on all channels at the same edge.
- rst_n pulsed low mid-period -> outputs go to 0 asynchronously; the period restarts from cnt=0 after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and dead-time state encoding for the multi-channel PWM.
// Dead-time insertion in pwm_multi_dt is enabled by defining PWM_DEADTIME_EN.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH    = 11;
  localparam int unsigned PWM_NCH      = 2;
  localparam int unsigned PWM_DT_WIDTH = 6;

  typedef enum logic [1:0] {
    LO         = 2'd0,
    HI         = 2'd1,
    DEAD_TO_HI = 2'd2,
    DEAD_TO_LO = 2'd3
  } dt_state_t;

endpackage

// File: rtl/pwm_dt_chan.sv
// One channel's dead-time generator: turns the registered compare into a
// non-overlapping high-side/low-side pair with a programmable gap.
module pwm_dt_chan
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                hi,
  output logic                lo
);

  localparam int unsigned CW = DT_WIDTH + 1;

  dt_state_t           state_q, state_d;
  logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
  logic                hi_q, hi_d;
  logic                lo_q, lo_d;
  logic                dt_zero_c;
  logic                dt_done_c;

  // Next state; a compare reversal inside a gap restarts the opposite gap
  always_comb begin
    state_d   = state_q;
    dt_cnt_d  = dt_cnt_q;
    dt_zero_c = (deadtime == '0);
    dt_done_c = (CW'(dt_cnt_q) + CW'(1)) >= CW'(deadtime);
    case (state_q)
      LO: begin
        if (raw) begin
          state_d  = dt_zero_c ? HI : DEAD_TO_HI;
          dt_cnt_d = '0;
        end
      end
      HI: begin
        if (!raw) begin
          state_d  = dt_zero_c ? LO : DEAD_TO_LO;
          dt_cnt_d = '0;
        end
      end
      DEAD_TO_HI: begin
        if (!raw) begin
          state_d  = DEAD_TO_LO;
          dt_cnt_d = '0;
        end else if (dt_done_c) begin
          state_d = HI;
        end else begin
          dt_cnt_d = dt_cnt_q + DT_WIDTH'(1);
        end
      end
      DEAD_TO_LO: begin
        if (raw) begin
          state_d  = DEAD_TO_HI;
          dt_cnt_d = '0;
        end else if (dt_done_c) begin
          state_d = LO;
        end else begin
          dt_cnt_d = dt_cnt_q + DT_WIDTH'(1);
        end
      end
      default: begin
        state_d  = DEAD_TO_LO;
        dt_cnt_d = '0;
      end
    endcase
    hi_d = (state_d == HI);
    lo_d = (state_d == LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DEAD_TO_LO;
      dt_cnt_q <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/pwm_multi_dt.sv
// Multi-channel PWM: shared period counter, double-buffered duty, per-channel
// compare and complementary outputs. Define PWM_DEADTIME_EN for dead-time.
module pwm_multi_dt
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter int unsigned NCH      = PWM_NCH,
  parameter int unsigned DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  duty,
  input  logic                  duty_vld,
  input  logic [DT_WIDTH-1:0]   deadtime,
  output logic                  period_start,
  output logic [NCH-1:0]        pwm_hi,
  output logic [NCH-1:0]        pwm_lo
);

  localparam int unsigned DW = NCH * WIDTH;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    pending_q, pending_d;
  logic [DW-1:0]    active_q, active_d;
  logic [NCH-1:0]   raw_q, raw_d;
  logic             period_start_q, period_start_d;
  logic             last_c;

  // A strobe on the last cycle of a period goes straight into active
  always_comb begin
    last_c         = (cnt_q == CNT_MAX);
    cnt_d          = cnt_q + WIDTH'(1);
    pending_d      = duty_vld ? duty : pending_q;
    active_d       = last_c ? pending_d : active_q;
    period_start_d = last_c;
    raw_d          = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      raw_d[i] = (cnt_q < active_q[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      pending_q      <= '0;
      active_q       <= '0;
      raw_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      active_q       <= active_d;
      raw_q          <= raw_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

`ifdef PWM_DEADTIME_EN
  for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
    pwm_dt_chan #(
      .DT_WIDTH (DT_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw_q[g]),
      .deadtime (deadtime),
      .hi       (pwm_hi[g]),
      .lo       (pwm_lo[g])
    );
  end
`else
  logic [NCH-1:0] hi_q, hi_d;
  logic [NCH-1:0] lo_q, lo_d;
  logic           unused_deadtime_c;

  assign unused_deadtime_c = ^deadtime;

  // Plain complementary outputs, no gap
  always_comb begin
    hi_d = raw_q;
    lo_d = ~raw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;
`endif

endmodule
